// File: rtl/pow2_decomposer_if.sv
// Request/term handshake bundle for pow2_decomposer.
// master drives requests and consumes terms; slave is the decomposer itself.
interface pow2_decomposer_if #(
    parameter int WIDTH = 5
);
    localparam int N_W = $clog2(WIDTH);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] num_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [N_W-1:0]   n_o;
    logic [WIDTH-1:0] m_o;
    logic [N_W-1:0]   beat_o;
    logic             last_o;
    logic             zero_o;

    modport master (
        output in_valid_i, num_i, out_ready_i,
        input  in_ready_o, out_valid_o, n_o, m_o, beat_o, last_o, zero_o
    );

    modport slave (
        input  in_valid_i, num_i, out_ready_i,
        output in_ready_o, out_valid_o, n_o, m_o, beat_o, last_o, zero_o
    );
endinterface

// File: rtl/pow2_decomposer.sv
// Sequential power-of-two decomposer: emits one set bit of num_i per term.
// Ports: clk_i, rst_i (sync, active-high), bus (slave side of pow2_decomposer_if).
module pow2_decomposer #(
    parameter int WIDTH     = 5,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pow2_decomposer_if.slave   bus
);
    localparam int N_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [N_W-1:0]   beat_q, beat_d;

    logic [N_W-1:0]   idx;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] rem;
    logic             last;
    logic             emit;

    // Priority pick: the loop's final hit wins, so scan direction sets order.
    always_comb begin
        idx = '0;
        sel = '0;
        if (LSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (work_q[i]) begin
                    idx    = N_W'(i);
                    sel    = '0;
                    sel[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (work_q[i]) begin
                    idx    = N_W'(i);
                    sel    = '0;
                    sel[i] = 1'b1;
                end
            end
        end
    end

    assign rem  = work_q & ~sel;
    assign last = (rem == '0);
    assign emit = (state_q == EMIT);

    always_comb begin
        bus.out_valid_o = emit;
        bus.n_o         = emit ? idx : '0;
        bus.m_o         = emit ? rem : '0;
        bus.beat_o      = emit ? beat_q : '0;
        bus.last_o      = emit && last;
        bus.zero_o      = emit && (work_q == '0);
        // Final-term handshake frees the slot in the same cycle.
        bus.in_ready_o  = !emit || (last && bus.out_ready_i);
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    work_d  = bus.num_i;
                    beat_d  = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready_i) begin
                    if (!last) begin
                        work_d = rem;
                        beat_d = beat_q + 1'b1;
                    end else if (bus.in_valid_i) begin
                        work_d = bus.num_i;
                        beat_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            beat_q  <= beat_d;
        end
    end
endmodule

// File: tb/tb_pow2_decomposer.sv
// Directed bench for pow2_decomposer: MSB-first and LSB-first instances.
// Ports: none (top-level bench).
module tb_pow2_decomposer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pow2_decomposer_if #(.WIDTH(5)) a ();
    pow2_decomposer_if #(.WIDTH(5)) b ();

    pow2_decomposer #(.WIDTH(5), .LSB_FIRST(1'b0)) dut_msb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (a)
    );

    pow2_decomposer #(.WIDTH(5), .LSB_FIRST(1'b1)) dut_lsb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic term_a(input string tag, input int n, input int m,
                          input int beat, input bit last, input bit zero);
        check({tag, ".valid"}, 32'(a.out_valid_o), 32'd1);
        check({tag, ".n"}, 32'(a.n_o), 32'(n));
        check({tag, ".m"}, 32'(a.m_o), 32'(m));
        check({tag, ".beat"}, 32'(a.beat_o), 32'(beat));
        check({tag, ".last"}, 32'(a.last_o), 32'(last));
        check({tag, ".zero"}, 32'(a.zero_o), 32'(zero));
    endtask

    task automatic idle_a(input string tag);
        check({tag, ".valid"}, 32'(a.out_valid_o), 32'd0);
        check({tag, ".in_ready"}, 32'(a.in_ready_o), 32'd1);
        check({tag, ".data"},
              32'({a.n_o, a.m_o, a.beat_o, a.last_o, a.zero_o}), 32'd0);
    endtask

    task automatic accept_a(input logic [4:0] num);
        a.in_valid_i = 1'b1;
        a.num_i      = num;
        tick();
        a.in_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        a.in_valid_i  = 1'b0;
        a.num_i       = '0;
        a.out_ready_i = 1'b1;
        b.in_valid_i  = 1'b0;
        b.num_i       = '0;
        b.out_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        idle_a("reset");
        check("reset.lsb_valid", 32'(b.out_valid_o), 32'd0);

        // 22 = 10110b, MSB first
        accept_a(5'd22);
        term_a("msb22.b0", 4, 6, 0, 1'b0, 1'b0);
        check("msb22.b0.in_ready", 32'(a.in_ready_o), 32'd0);
        tick();
        term_a("msb22.b1", 2, 2, 1, 1'b0, 1'b0);
        check("msb22.b1.in_ready", 32'(a.in_ready_o), 32'd0);
        tick();
        term_a("msb22.b2", 1, 0, 2, 1'b1, 1'b0);
        check("msb22.b2.in_ready", 32'(a.in_ready_o), 32'd1);
        tick();
        idle_a("msb22.done");

        // Zero request: one degenerate term
        accept_a(5'd0);
        term_a("zero", 0, 0, 0, 1'b1, 1'b1);
        tick();
        idle_a("zero.done");

        // Full count 31: bits 4..0, remainder shrinks to 2^n - 1
        accept_a(5'd31);
        for (int k = 0; k < 5; k++) begin
            term_a($sformatf("full.b%0d", k), 4 - k, (1 << (4 - k)) - 1,
                   k, k == 4, 1'b0);
            tick();
        end
        idle_a("full.done");

        // Backpressure on 12 = 01100b
        a.out_ready_i = 1'b0;
        accept_a(5'd12);
        for (int k = 0; k < 3; k++) begin
            term_a($sformatf("bp.hold%0d", k), 3, 4, 0, 1'b0, 1'b0);
            tick();
        end
        a.out_ready_i = 1'b1;
        #1;
        term_a("bp.release", 3, 4, 0, 1'b0, 1'b0);
        tick();
        term_a("bp.last", 2, 0, 1, 1'b1, 1'b0);
        tick();
        idle_a("bp.done");

        // Back-to-back: 8 then 3 with in_valid held high
        a.in_valid_i = 1'b1;
        a.num_i      = 5'd8;
        tick();
        term_a("chain.8", 3, 0, 0, 1'b1, 1'b0);
        check("chain.8.in_ready", 32'(a.in_ready_o), 32'd1);
        a.num_i = 5'd3;
        tick();
        a.in_valid_i = 1'b0;
        #1;
        term_a("chain.3.b0", 1, 1, 0, 1'b0, 1'b0);
        tick();
        term_a("chain.3.b1", 0, 0, 1, 1'b1, 1'b0);
        tick();
        idle_a("chain.done");

        // Reset during beat 1 of 21 = 10101b
        accept_a(5'd21);
        term_a("rst21.b0", 4, 5, 0, 1'b0, 1'b0);
        tick();
        term_a("rst21.b1", 2, 1, 1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        idle_a("rst21.after");
        accept_a(5'd2);
        term_a("rst21.new2", 1, 0, 0, 1'b1, 1'b0);
        tick();
        idle_a("rst21.done");

        // LSB-first instance, 22 = 10110b
        b.in_valid_i = 1'b1;
        b.num_i      = 5'd22;
        tick();
        b.in_valid_i = 1'b0;
        #1;
        check("lsb22.b0.n", 32'(b.n_o), 32'd1);
        check("lsb22.b0.m", 32'(b.m_o), 32'd20);
        check("lsb22.b0.last", 32'(b.last_o), 32'd0);
        tick();
        check("lsb22.b1.n", 32'(b.n_o), 32'd2);
        check("lsb22.b1.m", 32'(b.m_o), 32'd16);
        check("lsb22.b1.beat", 32'(b.beat_o), 32'd1);
        tick();
        check("lsb22.b2.n", 32'(b.n_o), 32'd4);
        check("lsb22.b2.m", 32'(b.m_o), 32'd0);
        check("lsb22.b2.last", 32'(b.last_o), 32'd1);
        tick();
        check("lsb22.done", 32'(b.out_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
